// File: rtl/mem_lsu_pkg.sv
// mem_lsu shared types: size encodings, FSM states, RAM base, byte-count helper.
// Imported by mem_lsu and lsu_align.
package mem_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [63:0] RAM_BASE = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      ACC0,
      ACC1,
      RESP
   } state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      logic [3:0] n;
      unique case (size)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// mem_lsu byte-lane aligner: 128-bit store data/mask build and
// load extraction with sign/zero extension from a two-beat buffer.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [2:0]   off,
   input  logic [1:0]   size,
   input  logic         is_unsigned,
   input  logic [63:0]  wdata,
   input  logic [127:0] rbuf,
   output logic [127:0] wide_data,
   output logic [127:0] wide_mask,
   output logic [63:0]  ldata
);

   logic [5:0]  sh;
   logic [7:0]  lane;
   logic [15:0] bmask;
   logic [63:0] raw;

   assign sh = {off, 3'b000};

   // Store path: shift data into its lanes, build a bit mask from byte lanes.
   always_comb begin
      wide_data = {64'b0, wdata} << sh;
      lane      = 8'hFF >> (4'd8 - size_bytes(size));
      bmask     = {8'b0, lane} << off;
      wide_mask = '0;
      for (int i = 0; i < 16; i++) begin
         wide_mask[i*8 +: 8] = {8{bmask[i]}};
      end
   end

   // Load path: bring the addressed byte to bit 0, then truncate and extend.
   always_comb begin
      raw = 64'(rbuf >> sh);
      unique case (size)
         SZ_B: ldata = is_unsigned ? {56'b0, raw[7:0]}
                                   : {{56{raw[7]}}, raw[7:0]};
         SZ_H: ldata = is_unsigned ? {48'b0, raw[15:0]}
                                   : {{48{raw[15]}}, raw[15:0]};
         SZ_W: ldata = is_unsigned ? {32'b0, raw[31:0]}
                                   : {{32{raw[31]}}, raw[31:0]};
         default: ldata = raw;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: one-at-a-time load/store unit driving the RAM data port.
// MEM_LSU_SPLIT_EN defined: 8-byte-crossing accesses split into two beats;
// undefined: crossing accesses are rejected with resp_err.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [RD_W-1:0] req_rd,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [RD_W-1:0] resp_rd,
   output logic            resp_err,
   output logic            dmem_en,
   output logic [XLEN-1:0] dmem_addr,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [XLEN-1:0] dmem_wmask,
   output logic            dmem_wen
);

   state_t state, nxt;

   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic            st_q;
   logic [RD_W-1:0] rd_q;
   logic [63:0]     lo_buf;
   logic [63:0]     hi_buf;

   logic            cross_q;
   logic [XLEN-1:0] base_q;
   logic [127:0]    wide_data;
   logic [127:0]    wide_mask;
   logic [63:0]     ldata;

   assign cross_q = ({1'b0, addr_q[2:0]} + size_bytes(size_q)) > 4'd8;
   assign base_q  = {addr_q[XLEN-1:3], 3'b000};

`ifndef MEM_LSU_SPLIT_EN
   logic cross_req;
   logic unused_hi;
   assign cross_req = ({1'b0, req_addr[2:0]} + size_bytes(req_size)) > 4'd8;
   assign unused_hi = ^{wide_data[127:64], wide_mask[127:64]};
   assign hi_buf    = '0;
`endif

   lsu_align u_align (
      .off         (addr_q[2:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .wdata       (wdata_q),
      .rbuf        ({hi_buf, lo_buf}),
      .wide_data   (wide_data),
      .wide_mask   (wide_mask),
      .ldata       (ldata)
   );

   // State register; reset abandons any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Request capture and load-beat buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         st_q    <= 1'b0;
         rd_q    <= '0;
         lo_buf  <= '0;
`ifdef MEM_LSU_SPLIT_EN
         hi_buf  <= '0;
`endif
      end else begin
         if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            st_q    <= req_store;
            rd_q    <= req_rd;
         end
         if (state == ACC0 && !st_q) lo_buf <= dmem_rdata;
`ifdef MEM_LSU_SPLIT_EN
         if (state == ACC1 && !st_q) hi_buf <= dmem_rdata;
`endif
      end
   end

   assign req_ready = (state == IDLE);
   assign resp_rd   = rd_q;

   // Next state, RAM port and response outputs.
   always_comb begin
      nxt        = state;
      dmem_en    = 1'b0;
      dmem_wen   = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_wmask = '0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_err   = 1'b0;
      case (state)
         IDLE: begin
`ifdef MEM_LSU_SPLIT_EN
            if (req_valid) nxt = ACC0;
`else
            if (req_valid) nxt = cross_req ? RESP : ACC0;
`endif
         end
         ACC0: begin
            dmem_en    = 1'b1;
            dmem_wen   = st_q & ~rst;
            dmem_addr  = base_q;
            dmem_wdata = wide_data[63:0];
            dmem_wmask = wide_mask[63:0];
`ifdef MEM_LSU_SPLIT_EN
            nxt = cross_q ? ACC1 : RESP;
`else
            nxt = RESP;
`endif
         end
`ifdef MEM_LSU_SPLIT_EN
         ACC1: begin
            dmem_en    = 1'b1;
            dmem_wen   = st_q & ~rst;
            dmem_addr  = base_q + 64'd8;
            dmem_wdata = wide_data[127:64];
            dmem_wmask = wide_mask[127:64];
            nxt        = RESP;
         end
`endif
         RESP: begin
            resp_valid = 1'b1;
            resp_data  = st_q ? '0 : ldata;
`ifndef MEM_LSU_SPLIT_EN
            if (cross_q) begin
               resp_err  = 1'b1;
               resp_data = '0;
            end
`endif
            if (resp_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

endmodule
